// File: rtl/core8_mem_copy_master_if.sv
// Avalon-MM master-side bundle towards a Core8 single-port on-chip memory (read latency 1).
interface core8_mem_copy_master_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_clken;

    modport master (
        output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken,
        input  avm_readdata
    );

    modport slave (
        input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata, avm_clken,
        output avm_readdata
    );
endinterface

// File: rtl/core8_mem_copy_master.sv
// Block word copy inside one Core8 on-chip memory; optional running checksum via CORE8_COPY_CHECKSUM_EN.
// Latency: 3 cycles per word (RD, LAT, WR), done pulses 3*len+1 cycles after start is accepted.
// No backpressure: memory is always ready; start is ignored unless the engine is idle.
module core8_mem_copy_master #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    core8_mem_copy_master_if.master avm
`ifdef CORE8_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int unsigned       MAX_WORDS = 2 ** ADDR_W;
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LAT  = 3'd2,
        S_WR   = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  src_ptr, dst_ptr;
    logic [LEN_W-1:0]   remaining;
    logic [DATA_W-1:0]  data_buf;
    logic [LEN_W-1:0]   len_eff;
    logic               accept;

    assign len_eff = (len > LEN_MAX) ? LEN_MAX : len;
    assign accept  = (state == S_IDLE) && start;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (start) state_nxt = (len == '0) ? S_FIN : S_RD;
            S_RD:   state_nxt = S_LAT;
            S_LAT:  state_nxt = S_WR;
            S_WR:   state_nxt = (remaining == LEN_W'(1)) ? S_FIN : S_RD;
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are pure state decodes, so reset forces them all to 0 one cycle later.
    always_comb begin
        busy               = (state != S_IDLE);
        done               = (state == S_FIN);
        avm.avm_chipselect = (state == S_RD) || (state == S_WR);
        avm.avm_write      = (state == S_WR);
        avm.avm_byteenable = avm.avm_chipselect ? '1 : '0;
        avm.avm_writedata  = (state == S_WR) ? data_buf : '0;
        avm.avm_clken      = ~reset;
        avm.avm_address    = '0;
        if (state == S_RD) avm.avm_address = src_ptr;
        if (state == S_WR) avm.avm_address = dst_ptr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            data_buf  <= '0;
        end else begin
            if (accept) begin
                src_ptr   <= src_addr;
                dst_ptr   <= dst_addr;
                remaining <= len_eff;
            end
            if (state == S_LAT) begin
                data_buf <= avm.avm_readdata;
            end
            // Pointers wrap naturally at the address width.
            if (state == S_WR) begin
                src_ptr   <= src_ptr + ADDR_W'(1);
                dst_ptr   <= dst_ptr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

`ifdef CORE8_COPY_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (state == S_WR) begin
            checksum <= checksum + data_buf;
        end
    end
`endif

endmodule

// File: tb/tb_core8_mem_copy_master.sv
module tb_core8_mem_copy_master;
    localparam int MEM_WORDS = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [12:0] src_addr = '0;
    logic [12:0] dst_addr = '0;
    logic [13:0] len = '0;
    logic        busy, done;
`ifdef CORE8_COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    core8_mem_copy_master_if #(.ADDR_W(13), .DATA_W(32)) bus ();

    core8_mem_copy_master #(.ADDR_W(13), .DATA_W(32), .LEN_W(14)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .avm      (bus)
`ifdef CORE8_COPY_CHECKSUM_EN
        ,
        .checksum (checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory slave: unregistered q, one cycle of read latency.
    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] rdata = '0;
    always @(posedge clk) begin
        if (bus.avm_chipselect && !bus.avm_write) rdata <= mem[bus.avm_address];
        if (bus.avm_chipselect && bus.avm_write)  mem[bus.avm_address] = bus.avm_writedata;
    end
    assign bus.avm_readdata = rdata;

    typedef struct {
        bit          wr;
        logic [12:0] addr;
        logic [31:0] data;
        int          cyc;
    } op_t;

    op_t         exp_q[$];
    int          done_q[$];
    logic [31:0] csum_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int busy_lo = 1;
    int busy_hi = 0;
    int zero_chk_cyc = -1;
    int clr_chk_cyc = -1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: samples mid-cycle and pops the scoreboard on every DUT output event.
    always @(negedge clk) begin
        op_t e;
        chk("clken", 64'(bus.avm_clken), 64'(!reset));
        chk("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
        chk("proto", 64'({bus.avm_byteenable, bus.avm_write && !bus.avm_chipselect}),
            64'({bus.avm_chipselect ? 4'hF : 4'h0, 1'b0}));
        if (bus.avm_chipselect) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL bus_unexpected: got access wr=%0d addr=%0h expected none (cycle %0d)",
                         bus.avm_write, bus.avm_address, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("bus_cycle", 64'(cyc), 64'(e.cyc));
                chk("bus_wr", 64'(bus.avm_write), 64'(e.wr));
                chk("bus_addr", 64'(bus.avm_address), 64'(e.addr));
                if (e.wr) chk("bus_wdata", 64'(bus.avm_writedata), 64'(e.data));
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL done_unexpected: got done=1 expected 0 (cycle %0d)", cyc);
            end else begin
                chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
`ifdef CORE8_COPY_CHECKSUM_EN
                if (csum_q.size() > 0) chk("checksum", 64'(checksum), 64'(csum_q.pop_front()));
`endif
            end
        end
        if (cyc == zero_chk_cyc) begin
            chk("reset_outs", 64'({busy, done, bus.avm_chipselect, bus.avm_write, bus.avm_byteenable,
                                   bus.avm_address, bus.avm_writedata}), 64'(0));
`ifdef CORE8_COPY_CHECKSUM_EN
            chk("reset_csum", 64'(checksum), 64'(0));
`endif
        end
`ifdef CORE8_COPY_CHECKSUM_EN
        if (cyc == clr_chk_cyc) chk("csum_clear", 64'(checksum), 64'(0));
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int a, input logic [31:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Reference: word i is read in cycle c0+3i+1 and written in c0+3i+3, ascending, no memmove fix-up.
    task automatic run_copy(input logic [12:0] s, input logic [12:0] d, input logic [13:0] l,
                            input bit extra, input bit fin_start, input int rst_off);
        int c0, n, last, rst_at, rc, wc, sa, da;
        logic [31:0] v, sum;
        c0 = cyc;
        n = (l > 14'd8192) ? 8192 : int'(l);
        rst_at = (rst_off >= 0) ? c0 + rst_off : -1;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            rc = c0 + 3 * i + 1;
            wc = c0 + 3 * i + 3;
            sa = (int'(s) + i) % MEM_WORDS;
            da = (int'(d) + i) % MEM_WORDS;
            if (rst_at < 0 || rc <= rst_at)
                exp_q.push_back('{wr: 1'b0, addr: sa[12:0], data: 32'h0, cyc: rc});
            if (rst_at < 0 || wc <= rst_at) begin
                v = ref_mem[sa];
                ref_mem[da] = v;
                sum = sum + v;
                exp_q.push_back('{wr: 1'b1, addr: da[12:0], data: v, cyc: wc});
            end
        end
        last = c0 + 3 * n + 1;
        busy_lo = c0 + 1;
        busy_hi = (rst_at >= 0) ? rst_at : last;
        if (rst_at < 0) begin
            done_q.push_back(last);
            csum_q.push_back(sum);
        end else begin
            zero_chk_cyc = rst_at + 1;
        end
        clr_chk_cyc = c0 + 1;
        start = 1'b1;
        src_addr = s;
        dst_addr = d;
        len = l;
        step();
        for (int t = c0 + 1; t <= busy_hi + 2; t++) begin
            start = 1'b0;
            src_addr = 13'($urandom);
            dst_addr = 13'($urandom);
            len = 14'($urandom_range(1, 9));
            reset = (t == rst_at);
            if (extra && t < last && (t == c0 + 2 || t == c0 + 5)) start = 1'b1;
            if (fin_start && t == last) start = 1'b1;
            step();
        end
        chk("sb_drain", 64'(exp_q.size() + done_q.size()), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) set_word(i, $urandom);
        repeat (3) step();
        reset = 1'b0;
        zero_chk_cyc = cyc;
        repeat (2) step();

        for (int i = 0; i < 4; i++) set_word(16'h10 + i, $urandom);
        run_copy(13'h0010, 13'h0100, 14'd4, 1'b0, 1'b0, -1);
        run_copy(13'h0010, 13'h0100, 14'd4, 1'b1, 1'b1, -1);
        run_copy(13'($urandom), 13'($urandom), 14'd0, 1'b0, 1'b1, -1);
        run_copy(13'h1FFE, 13'h0800, 14'd4, 1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++) set_word(16'h10 + i, $urandom);
        run_copy(13'h0010, 13'h0100, 14'd4, 1'b0, 1'b0, 5);
        run_copy(13'h0020, 13'h0022, 14'd6, 1'b0, 1'b0, -1);
        run_copy(13'h0032, 13'h0030, 14'd6, 1'b0, 1'b0, -1);
`ifdef CORE8_COPY_CHECKSUM_EN
        set_word(16'h40, 32'h0000_0001);
        set_word(16'h41, 32'h0000_0002);
        set_word(16'h42, 32'hFFFF_FFFF);
        run_copy(13'h0040, 13'h0300, 14'd3, 1'b0, 1'b0, -1);
`endif
        for (int k = 0; k < 8; k++)
            run_copy(13'($urandom), 13'($urandom), 14'($urandom_range(0, 24)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        run_copy(13'h0123, 13'h1456, 14'h3FFF, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
